fpu: RTL and testbench



---
 rtl/fpu.sv | 143 ++++++++++++++
 tb/tb_fpu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fpu.sv
// rtl/fpu.sv - two-stage binary32 adder; FPU_ROUND_NEAREST_EN selects RNE, else truncation
module fpu (
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic [31:0] Op_A_in,
    input  logic [31:0] Op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0010;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0100;
    localparam logic [3:0] ST_INEXACT   = 4'b1000;

    logic [7:0]  exp_a, exp_b, exp_big, exp_small, shift_amt;
    logic [23:0] man_a, man_b, man_big, man_small;
    logic        a_is_big;
    logic [49:0] shifted;
    logic [26:0] small_field;

    // exp=0 operands (zeros and denormals) contribute nothing
    assign exp_a = Op_A_in[30:23];
    assign exp_b = Op_B_in[30:23];
    assign man_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, Op_A_in[22:0]};
    assign man_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, Op_B_in[22:0]};

    assign a_is_big  = {exp_a, man_a} >= {exp_b, man_b};
    assign exp_big   = a_is_big ? exp_a : exp_b;
    assign exp_small = a_is_big ? exp_b : exp_a;
    assign man_big   = a_is_big ? man_a : man_b;
    assign man_small = a_is_big ? man_b : man_a;
    assign shift_amt = exp_big - exp_small;

    // small field: 24 mantissa bits, guard, round, then sticky collecting everything shifted past
    assign shifted     = {man_small, 26'd0} >> shift_amt;
    assign small_field = (shift_amt >= 8'd26) ? {26'd0, |man_small}
                                              : {shifted[49:24], |shifted[23:0]};

    logic        s1_valid, s1_inf, s1_inf_sign, s1_sign, s1_sub;
    logic [7:0]  s1_exp;
    logic [23:0] s1_man_big;
    logic [26:0] s1_small;

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_exp      <= 8'd0;
            s1_man_big  <= 24'd0;
            s1_small    <= 27'd0;
        end else begin
            s1_valid    <= 1'b1;
            s1_inf      <= (exp_a == 8'hFF) || (exp_b == 8'hFF);
            s1_inf_sign <= (exp_a == 8'hFF) ? Op_A_in[31] : Op_B_in[31];
            s1_sign     <= a_is_big ? Op_A_in[31] : Op_B_in[31];
            s1_sub      <= Op_A_in[31] ^ Op_B_in[31];
            s1_exp      <= exp_big;
            s1_man_big  <= man_big;
            s1_small    <= small_field;
        end
    end

    logic [27:0]       sum;
    logic [26:0]       dif, norm;
    logic [4:0]        lzc;
    logic signed [9:0] exp_pre, exp_fin;
    logic              round_up;
    logic [24:0]       mant_rnd;
    logic [22:0]       mant_fin;
    logic [31:0]       res_data;
    logic [3:0]        res_status;

    always_comb begin
        sum = {1'b0, s1_man_big, 3'b000} + {1'b0, s1_small};
        dif = {s1_man_big, 3'b000} - s1_small;
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (dif[i]) lzc = 5'(26 - i);
        end

        if (!s1_sub) begin
            if (sum[27]) begin
                norm    = {sum[27:2], sum[1] | sum[0]};
                exp_pre = $signed({2'b00, s1_exp}) + 10'sd1;
            end else begin
                norm    = sum[26:0];
                exp_pre = $signed({2'b00, s1_exp});
            end
        end else begin
            norm    = dif << lzc;
            exp_pre = $signed({2'b00, s1_exp}) - $signed({5'd0, lzc});
        end

`ifdef FPU_ROUND_NEAREST_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
        round_up = 1'b0;
`endif
        mant_rnd = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_rnd[24]) begin
            mant_fin = mant_rnd[23:1];
            exp_fin  = exp_pre + 10'sd1;
        end else begin
            mant_fin = mant_rnd[22:0];
            exp_fin  = exp_pre;
        end

        if (s1_inf) begin
            res_data   = {s1_inf_sign, 8'hFF, 23'd0};
            res_status = ST_OVERFLOW;
        end else if (norm == 27'd0) begin
            res_data   = 32'd0;
            res_status = ST_EXACT;
        end else if (exp_fin >= 10'sd255) begin
            res_data   = {s1_sign, 8'hFF, 23'd0};
            res_status = ST_OVERFLOW;
        end else if (exp_fin <= 10'sd0) begin
            res_data   = {s1_sign, 31'd0};
            res_status = ST_UNDERFLOW;
        end else begin
            res_data   = {s1_sign, exp_fin[7:0], mant_fin};
            res_status = (|norm[2:0]) ? ST_INEXACT : ST_EXACT;
        end
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            data_out   <= 32'd0;
            status_out <= 4'b0000;
        end else if (s1_valid) begin
            data_out   <= res_data;
            status_out <= res_status;
        end else begin
            data_out   <= 32'd0;
            status_out <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_fpu.sv
// tb/tb_fpu.sv - randomized self-checking bench for fpu against an exact-arithmetic model
module tb_fpu;

    logic        clock_100Khz;
    logic        reset;
    logic [31:0] Op_A_in, Op_B_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] va_q[$];
    logic [31:0] vb_q[$];
    logic [35:0] exp_q[$];

    fpu dut (
        .clock_100Khz(clock_100Khz),
        .reset(reset),
        .Op_A_in(Op_A_in),
        .Op_B_in(Op_B_in),
        .data_out(data_out),
        .status_out(status_out)
    );

    initial clock_100Khz = 1'b0;
    always #5 clock_100Khz = ~clock_100Khz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Exact sum on a wide integer grid, then rounded/flagged by the format rules
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, emin, p, e, sh;
        logic        sa, sb, sg, inexact;
        logic [299:0] ma, mb, m, mant, rem, half, one;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        if (ea == 255 || eb == 255)
            return {4'b0010, (ea == 255) ? sa : sb, 8'hFF, 23'd0};
        ma = (ea == 0) ? 300'd0 : 300'({1'b1, a[22:0]});
        mb = (eb == 0) ? 300'd0 : 300'({1'b1, b[22:0]});
        emin = (ea < eb) ? ea : eb;
        ma = ma << (ea - emin);
        mb = mb << (eb - emin);
        if (sa == sb) begin m = ma + mb; sg = sa; end
        else if (ma >= mb) begin m = ma - mb; sg = sa; end
        else begin m = mb - ma; sg = sb; end
        if (m == 300'd0) return {4'b0001, 32'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        e = emin + p - 23;
        inexact = 1'b0;
        one = 300'd1;
        if (p > 23) begin
            sh = p - 23;
            mant = m >> sh;
            rem = m & ((one << sh) - one);
            half = one << (sh - 1);
            inexact = (rem != 300'd0);
`ifdef FPU_ROUND_NEAREST_EN
            if (rem > half || (rem == half && mant[0])) mant = mant + one;
`endif
            if (mant[24]) begin mant = mant >> 1; e++; end
        end else begin
            mant = m << (23 - p);
        end
        if (e >= 255) return {4'b0010, sg, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0100, sg, 31'd0};
        return {inexact ? 4'b1000 : 4'b0001, sg, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_near(input logic [31:0] r);
        int          kind, e;
        logic [22:0] f;
        kind = int'($urandom_range(0, 15));
        f = 23'($urandom);
        e = int'(r[30:23]);
        case (kind)
            0: e = 0;
            1: e = 255;
            2, 3: e = int'($urandom_range(1, 254));
            4: e = int'($urandom_range(249, 254));
            5: e = int'($urandom_range(1, 6));
            6, 7: return {~r[31], r[30:23], r[22:0] ^ 23'($urandom_range(0, 7))};
            default: begin
                e = e + int'($urandom_range(0, 56)) - 28;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
            end
        endcase
        return {1'($urandom), e[7:0], f};
    endfunction

    task automatic push_vec(input logic [31:0] a, input logic [31:0] b, input logic [35:0] want);
        va_q.push_back(a);
        vb_q.push_back(b);
        exp_q.push_back(want);
    endtask

    // Back-to-back operands; each result is expected exactly two edges after its operands
    task automatic run_stream(input string tag);
        int n;
        n = va_q.size();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clock_100Khz);
            if (k >= 2) begin
                check($sformatf("%s_data[%0d]", tag, k - 2), data_out, exp_q[k - 2][31:0]);
                check($sformatf("%s_status[%0d]", tag, k - 2), {28'd0, status_out}, {28'd0, exp_q[k - 2][35:32]});
            end
            if (k < n) begin
                Op_A_in = va_q[k];
                Op_B_in = vb_q[k];
            end
        end
        va_q.delete(); vb_q.delete(); exp_q.delete();
    endtask

    initial begin
        logic [31:0] a, b;
        reset = 1'b0;
        Op_A_in = 32'h40000000;
        Op_B_in = 32'h40800000;
        repeat (3) @(negedge clock_100Khz);
        check("reset_data", data_out, 32'h0);
        check("reset_status", {28'd0, status_out}, 32'h0);

        reset = 1'b1;
        @(negedge clock_100Khz);
        check("flush_status", {28'd0, status_out}, 32'h0);
        check("flush_data", data_out, 32'h0);
        @(negedge clock_100Khz);
        check("first_data", data_out, 32'h40C00000);
        check("first_status", {28'd0, status_out}, 32'h1);

        push_vec(32'h40000000, 32'h40800000, {4'b0001, 32'h40C00000});
        push_vec(32'h41800000, 32'hC1800000, {4'b0001, 32'h00000000});
        push_vec(32'h41700000, 32'hC0C00000, {4'b0001, 32'h41100000});
        push_vec(32'h7F7FFFFF, 32'h7F7FFFFF, {4'b0010, 32'h7F800000});
        push_vec(32'h00800001, 32'h80800000, {4'b0100, 32'h00000000});
`ifdef FPU_ROUND_NEAREST_EN
        push_vec(32'h3F800000, 32'h33C00000, {4'b1000, 32'h3F800001});
`else
        push_vec(32'h3F800000, 32'h33C00000, {4'b1000, 32'h3F800000});
`endif
        push_vec(32'hFF800000, 32'h7F800000, {4'b0010, 32'hFF800000});
        push_vec(32'h3F800000, 32'h7FC00000, {4'b0010, 32'h7F800000});
        run_stream("directed");

        for (int i = 0; i < 400; i++) begin
            a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            b = rand_near(a);
            if ($urandom_range(0, 1) == 1) push_vec(a, b, model(a, b));
            else push_vec(b, a, model(b, a));
        end
        run_stream("random");

        Op_A_in = 32'h3F800000;
        Op_B_in = 32'h33C00000;
        repeat (2) @(negedge clock_100Khz);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_100Khz);
            check($sformatf("hold_data[%0d]", k), data_out, model(32'h3F800000, 32'h33C00000) >> 0);
            check($sformatf("hold_status[%0d]", k), {28'd0, status_out}, 32'h8);
        end

        #2 reset = 1'b0;
        #1;
        check("midreset_data", data_out, 32'h0);
        check("midreset_status", {28'd0, status_out}, 32'h0);
        Op_A_in = 32'h40000000;
        Op_B_in = 32'h40800000;
        @(negedge clock_100Khz);
        reset = 1'b1;
        @(negedge clock_100Khz);
        check("midreset_flush_status", {28'd0, status_out}, 32'h0);
        @(negedge clock_100Khz);
        check("midreset_resume", data_out, 32'h40C00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
